// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Definitions shared by the control unit and the ALU datapath.
//             Control-word bit map, flag bit positions, sequencer state
//             encoding and the ALU operation decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Control-word bit positions, matching the control unit's microword
    localparam int c_bit_mbr2br    = 6;
    localparam int c_bit_div       = 9;
    localparam int c_bit_mbr2acc   = 10;
    localparam int c_bit_alu2mbr   = 16;
    localparam int c_bit_acc_clear = 21;
    localparam int c_bit_add       = 22;
    localparam int c_bit_sub       = 23;
    localparam int c_bit_and       = 24;
    localparam int c_bit_or        = 25;
    localparam int c_bit_not       = 26;
    localparam int c_bit_lsl       = 27;
    localparam int c_bit_lsr       = 28;
    localparam int c_bit_mpy       = 29;
    localparam int c_bit_asl       = 30;
    localparam int c_bit_asr       = 31;

    // Status flag bit positions
    localparam int c_flag_n  = 0;
    localparam int c_flag_z  = 1;
    localparam int c_flag_c  = 2;
    localparam int c_flag_v  = 3;
    localparam int c_flag_dz = 4;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } seq_state_t;

    // The one ACC-writing operation selected in a cycle
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_CLEAR = 4'd1,
        OP_LOAD  = 4'd2,
        OP_DIV   = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_NOT   = 4'd8,
        OP_LSL   = 4'd9,
        OP_LSR   = 4'd10,
        OP_MPY   = 4'd11,
        OP_ASL   = 4'd12,
        OP_ASR   = 4'd13
    } op_sel_t;

    // acc_clear beats mbr2acc, which beats the lowest-numbered op bit.
    // div yields to mpy when both are present in the same word.
    function automatic op_sel_t decode_op(input logic [31:0] cw);
        op_sel_t sel;
        sel = OP_NONE;
        if (cw[c_bit_acc_clear])                     sel = OP_CLEAR;
        else if (cw[c_bit_mbr2acc])                  sel = OP_LOAD;
        else if (cw[c_bit_div] && !cw[c_bit_mpy])    sel = OP_DIV;
        else if (cw[c_bit_add])                      sel = OP_ADD;
        else if (cw[c_bit_sub])                      sel = OP_SUB;
        else if (cw[c_bit_and])                      sel = OP_AND;
        else if (cw[c_bit_or])                       sel = OP_OR;
        else if (cw[c_bit_not])                      sel = OP_NOT;
        else if (cw[c_bit_lsl])                      sel = OP_LSL;
        else if (cw[c_bit_lsr])                      sel = OP_LSR;
        else if (cw[c_bit_mpy])                      sel = OP_MPY;
        else if (cw[c_bit_asl])                      sel = OP_ASL;
        else if (cw[c_bit_asr])                      sel = OP_ASR;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_seq
//  Purpose  : Iterative signed multiply / restoring divide. Works on operand
//             magnitudes for WIDTH cycles, then applies signs in one FIX
//             cycle during which done is high and the result is valid.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             is_div,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] partial_hi
);

    localparam int c_msb   = WIDTH - 1;
    localparam int c_cnt_w = $clog2(WIDTH);

    seq_state_t         r_state;
    logic [WIDTH-1:0]   r_hi;       // mul: upper product / div: remainder
    logic [WIDTH-1:0]   r_lo;       // mul: multiplier->lower product / div: dividend->quotient
    logic [WIDTH-1:0]   r_b;        // multiplicand or divisor magnitude
    logic               r_neg_q;    // sign of product or quotient
    logic               r_neg_r;    // sign of remainder (dividend sign)
    logic               r_div;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_last;

    // Per-step datapath: magnitudes, shift-add sum, trial subtraction, sign fix
    always_comb begin
        w_abs_a    = op_a[c_msb] ? -op_a : op_a;
        w_abs_b    = op_b[c_msb] ? -op_b : op_b;
        w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        // remainder is always below the divisor, so its top bit is clear here
        w_rem_sh   = {r_hi, r_lo[c_msb]};
        w_trial    = w_rem_sh - {1'b0, r_b};
        w_last     = (r_cnt == c_cnt_w'(WIDTH - 1));
        w_prod     = {r_hi, r_lo};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
    end

    // Status and result presentation
    always_comb begin
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_FIX);
        is_div     = r_div;
        partial_hi = r_hi;
        result_hi  = r_div ? (r_neg_r ? -r_hi : r_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
        result_lo  = r_div ? (r_neg_q ? -r_lo : r_lo) : w_prod_fix[c_msb:0];
    end

    // Sequencer FSM and iteration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_hi    <= '0;
                        r_lo    <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_neg_q <= op_a[c_msb] ^ op_b[c_msb];
                        r_neg_r <= op_a[c_msb];
                        r_div   <= op_div;
                        r_cnt   <= '0;
                        r_state <= op_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_hi  <= w_sum[WIDTH:1];
                    r_lo  <= {w_sum[0], r_lo[c_msb:1]};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) r_state <= ST_FIX;
                end
                ST_DIV: begin
                    if (!w_trial[WIDTH]) begin
                        r_hi <= w_trial[c_msb:0];
                        r_lo <= {r_lo[c_msb-1:0], 1'b1};
                    end else begin
                        r_hi <= w_rem_sh[c_msb:0];
                        r_lo <= {r_lo[c_msb-1:0], 1'b0};
                    end
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Accumulator datapath stage. Holds ACC, BR and MR, executes
//             single-cycle arithmetic/logic/shift ops and hands multiply and
//             divide to the iterative sequencer. Reports N/Z/C/V/DZ and busy.
//  Revision : 1.0 - initial release
// ============================================================================
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      control_signal,
    input  logic [WIDTH-1:0] mbr_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_out_valid,
    output logic [7:0]       flags,
    output logic             busy
);

    localparam int c_msb = WIDTH - 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_br;
    logic [WIDTH-1:0] r_mr;
    logic             r_c;
    logic             r_v;
    logic             r_dz;

    op_sel_t          w_op;
    logic             w_div_zero;
    logic             w_start;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_v;
    logic             w_sub_v;
    logic             w_asl_v;

    logic             w_seq_busy;
    logic             w_seq_done;
    logic             w_seq_is_div;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_partial;

    // Operation select and single-cycle arithmetic
    always_comb begin
        w_op       = decode_op(control_signal);
        w_div_zero = (r_br == '0);
        // divide by zero finishes without the sequencer
        w_start    = !w_seq_busy &&
                     ((w_op == OP_MPY) || ((w_op == OP_DIV) && !w_div_zero));
        w_add      = {1'b0, r_acc} + {1'b0, r_br};
        // top bit of the widened difference is the borrow
        w_sub      = {1'b0, r_acc} - {1'b0, r_br};
        w_add_v    = (r_acc[c_msb] == r_br[c_msb]) && (w_add[c_msb] != r_acc[c_msb]);
        w_sub_v    = (r_acc[c_msb] != r_br[c_msb]) && (w_sub[c_msb] != r_acc[c_msb]);
        w_asl_v    = r_acc[c_msb] ^ r_acc[c_msb-1];
    end

    alu_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .op_div     (w_op == OP_DIV),
        .op_a       (r_acc),
        .op_b       (r_br),
        .busy       (w_seq_busy),
        .done       (w_seq_done),
        .is_div     (w_seq_is_div),
        .result_hi  (w_res_hi),
        .result_lo  (w_res_lo),
        .partial_hi (w_partial)
    );

    // BR loads from MBR whenever asked, even while the sequencer runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br <= '0;
        end else if (control_signal[c_bit_mbr2br]) begin
            r_br <= mbr_in;
        end
    end

    // ACC/MR/sticky flag update: sequencer result first, then the selected op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_mr  <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_seq_done) begin
            r_acc <= w_res_lo;
            r_mr  <= w_res_hi;
            if (w_seq_is_div) r_dz <= 1'b0;
        end else if (!w_seq_busy) begin
            case (w_op)
                OP_CLEAR: begin
                    r_acc <= '0;
                    r_c   <= 1'b0;
                    r_v   <= 1'b0;
                    r_dz  <= 1'b0;
                end
                OP_LOAD: r_acc <= mbr_in;
                OP_DIV: begin
                    if (w_div_zero) begin
                        r_acc <= '1;
                        r_mr  <= r_acc;
                        r_dz  <= 1'b1;
                    end
                end
                OP_ADD: begin
                    r_acc <= w_add[c_msb:0];
                    r_c   <= w_add[WIDTH];
                    r_v   <= w_add_v;
                end
                OP_SUB: begin
                    r_acc <= w_sub[c_msb:0];
                    r_c   <= w_sub[WIDTH];
                    r_v   <= w_sub_v;
                end
                OP_AND: r_acc <= r_acc & r_br;
                OP_OR:  r_acc <= r_acc | r_br;
                OP_NOT: r_acc <= ~r_br;
                OP_LSL: begin
                    r_acc <= {r_acc[c_msb-1:0], 1'b0};
                    r_c   <= r_acc[c_msb];
                    r_v   <= 1'b0;
                end
                OP_ASL: begin
                    r_acc <= {r_acc[c_msb-1:0], 1'b0};
                    r_c   <= r_acc[c_msb];
                    r_v   <= w_asl_v;
                end
                OP_LSR: begin
                    r_acc <= {1'b0, r_acc[c_msb:1]};
                    r_c   <= r_acc[0];
                end
                OP_ASR: begin
                    r_acc <= {r_acc[c_msb], r_acc[c_msb:1]};
                    r_c   <= r_acc[0];
                end
                default: begin
                    // OP_NONE, and OP_MPY which the sequencer handles
                end
            endcase
        end
    end

    // Outputs: MR shows the running partial while the sequencer is active
    always_comb begin
        acc_out            = r_acc;
        alu_out            = w_seq_busy ? w_partial : r_mr;
        alu_out_valid      = control_signal[c_bit_alu2mbr] && !w_seq_busy;
        busy               = w_seq_busy;
        flags              = '0;
        flags[c_flag_n]    = r_acc[c_msb];
        flags[c_flag_z]    = (r_acc == '0);
        flags[c_flag_c]    = r_c;
        flags[c_flag_v]    = r_v;
        flags[c_flag_dz]   = r_dz;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Self-checking bench for alu: directed scenarios plus random
//             control words compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int B_MBR2BR = 6,  B_DIV = 9,  B_MBR2ACC = 10, B_ALU2MBR = 16;
    localparam int B_CLR = 21, B_ADD = 22, B_SUB = 23, B_AND = 24, B_OR = 25;
    localparam int B_NOT = 26, B_LSL = 27, B_LSR = 28, B_MPY = 29, B_ASL = 30, B_ASR = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] control_signal = '0;
    logic [15:0] mbr_in = '0;
    logic [15:0] acc_out;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic [7:0]  flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_acc = '0, m_br = '0, m_mr = '0;
    logic        m_c = 1'b0, m_v = 1'b0, m_dz = 1'b0;

    alu #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .mbr_in         (mbr_in),
        .acc_out        (acc_out),
        .alu_out        (alu_out),
        .alu_out_valid  (alu_out_valid),
        .flags          (flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] cb(input int b);
        return 32'd1 << b;
    endfunction

    function automatic int sx(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic logic [7:0] m_flags();
        return {3'b000, m_dz, m_v, m_c, (m_acc == 16'h0), m_acc[15]};
    endfunction

    // Applies one accepted control word to the model; multi=1 if it starts mul/div
    task automatic model_apply(input logic [31:0] cw, input logic [15:0] mbr, output bit multi);
        int order [11];
        int sel, a, b, r, q, rm;
        longint p;
        order = '{B_DIV, B_ADD, B_SUB, B_AND, B_OR, B_NOT, B_LSL, B_LSR, B_MPY, B_ASL, B_ASR};
        multi = 0;
        a = sx(m_acc);
        b = sx(m_br);
        sel = -1;
        if (cw[B_CLR]) sel = B_CLR;
        else if (cw[B_MBR2ACC]) sel = B_MBR2ACC;
        else begin
            for (int i = 0; i < 11; i++)
                if (sel < 0 && cw[order[i]] && !(order[i] == B_DIV && cw[B_MPY])) sel = order[i];
        end
        case (sel)
            B_CLR:     begin m_acc = 16'h0; m_c = 0; m_v = 0; m_dz = 0; end
            B_MBR2ACC: m_acc = mbr;
            B_ADD: begin
                r = int'(m_acc) + int'(m_br);
                m_c = (r > 65535);
                m_v = (a + b > 32767) || (a + b < -32768);
                m_acc = r[15:0];
            end
            B_SUB: begin
                m_c = (m_acc < m_br);
                m_v = (a - b > 32767) || (a - b < -32768);
                m_acc = m_acc - m_br;
            end
            B_AND: m_acc = m_acc & m_br;
            B_OR:  m_acc = m_acc | m_br;
            B_NOT: m_acc = ~m_br;
            B_LSL: begin m_c = m_acc[15]; m_v = 0; m_acc = m_acc << 1; end
            B_ASL: begin
                m_c = m_acc[15];
                m_v = (a * 2 > 32767) || (a * 2 < -32768);
                m_acc = m_acc << 1;
            end
            B_LSR: begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
            B_ASR: begin m_c = m_acc[0]; m_acc = 16'(a >>> 1); end
            B_MPY: begin
                p = longint'(a) * longint'(b);
                m_acc = p[15:0];
                m_mr  = p[31:16];
                multi = 1;
            end
            B_DIV: begin
                if (b == 0) begin
                    m_mr  = m_acc;
                    m_acc = 16'hFFFF;
                    m_dz  = 1;
                end else begin
                    q = a / b;
                    rm = a % b;
                    m_acc = 16'(q);
                    m_mr  = 16'(rm);
                    m_dz  = 0;
                    multi = 1;
                end
            end
            default: ;
        endcase
        if (cw[B_MBR2BR]) m_br = mbr;
    endtask

    task automatic model_reset();
        m_acc = '0; m_br = '0; m_mr = '0; m_c = 0; m_v = 0; m_dz = 0;
    endtask

    // Drives one control word for a cycle; for mul/div waits (bounded) for busy to drop
    task automatic issue(input logic [31:0] cw, input logic [15:0] mbr, output bit multi, output int cyc);
        model_apply(cw, mbr, multi);
        control_signal = cw;
        mbr_in = mbr;
        @(posedge clk); #1;
        control_signal = '0;
        cyc = 0;
        if (multi) begin
            while (busy === 1'b1 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (acc_out !== 16'h0) begin bad++; $display("FAIL reset_acc got=%h want=0000", acc_out); end
        total++; if (alu_out !== 16'h0) begin bad++; $display("FAIL reset_mr got=%h want=0000", alu_out); end
        total++; if (flags !== 8'h02) begin bad++; $display("FAIL reset_flags got=%h want=02", flags); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_load();
        bit mu; int cy;
        issue(cb(B_CLR) | cb(B_MBR2BR), 16'h0005, mu, cy);
        issue(cb(B_ADD), 16'h0, mu, cy);
        total++; if (acc_out !== 16'h0005) begin bad++; $display("FAIL load_add_acc got=%h want=0005", acc_out); end
        total++; if (flags !== 8'h00) begin bad++; $display("FAIL load_add_flags got=%h want=00", flags); end
    endtask

    task automatic test_overflow();
        bit mu; int cy;
        issue(cb(B_MBR2BR), 16'h0001, mu, cy);
        issue(cb(B_MBR2ACC), 16'h7FFF, mu, cy);
        issue(cb(B_ADD), 16'h0, mu, cy);
        total++; if (acc_out !== 16'h8000) begin bad++; $display("FAIL ovf_add_acc got=%h want=8000", acc_out); end
        total++; if (flags !== 8'h09) begin bad++; $display("FAIL ovf_add_flags got=%h want=09", flags); end
        issue(cb(B_SUB), 16'h0, mu, cy);
        total++; if (acc_out !== 16'h7FFF) begin bad++; $display("FAIL ovf_sub_acc got=%h want=7fff", acc_out); end
        total++; if (flags !== 8'h08) begin bad++; $display("FAIL ovf_sub_flags got=%h want=08", flags); end
    endtask

    task automatic test_shifts();
        bit mu; int cy;
        int          op  [4];
        logic [15:0] ini [4];
        logic [15:0] res [4];
        logic [1:0]  vc  [4];
        op  = '{B_ASR, B_LSR, B_LSL, B_ASL};
        ini = '{16'h8004, 16'h8004, 16'h8004, 16'h4000};
        res = '{16'hC002, 16'h4002, 16'h0008, 16'h8000};
        vc  = '{2'b00, 2'b00, 2'b01, 2'b10};
        issue(cb(B_CLR), 16'h0, mu, cy);
        for (int i = 0; i < 4; i++) begin
            issue(cb(B_MBR2ACC), ini[i], mu, cy);
            issue(cb(op[i]), 16'h0, mu, cy);
            total++; if (acc_out !== res[i]) begin bad++; $display("FAIL shift%0d_acc got=%h want=%h", i, acc_out, res[i]); end
            total++; if (flags[3:2] !== vc[i]) begin bad++; $display("FAIL shift%0d_vc got=%b want=%b", i, flags[3:2], vc[i]); end
        end
    endtask

    task automatic test_mpy();
        bit mu; int cy; logic vbad;
        issue(cb(B_MBR2BR), 16'h0005, mu, cy);
        issue(cb(B_MBR2ACC), 16'hFFFD, mu, cy);
        model_apply(cb(B_MPY) | cb(B_ALU2MBR), 16'h0, mu);
        control_signal = cb(B_MPY) | cb(B_ALU2MBR);
        @(posedge clk); #1;
        cy = 0;
        vbad = 1'b0;
        while (busy === 1'b1 && cy < 100) begin
            if (alu_out_valid !== 1'b0) vbad = 1'b1;
            control_signal = cb(B_ADD) | cb(B_SUB) | cb(B_CLR) | cb(B_MBR2ACC) | cb(B_MPY)
                           | cb(B_DIV) | cb(B_ALU2MBR) | ((cy == 3) ? cb(B_MBR2BR) : 32'h0);
            mbr_in = 16'h1234;
            if (cy == 3) m_br = 16'h1234;
            @(posedge clk); #1;
            cy++;
        end
        control_signal = cb(B_ALU2MBR);
        #1;
        total++; if (cy != 17) begin bad++; $display("FAIL mpy_busy_cycles got=%0d want=17", cy); end
        total++; if (vbad !== 1'b0) begin bad++; $display("FAIL mpy_valid_while_busy got=1 want=0"); end
        total++; if (acc_out !== 16'hFFF1) begin bad++; $display("FAIL mpy_acc got=%h want=fff1", acc_out); end
        total++; if (alu_out !== 16'hFFFF) begin bad++; $display("FAIL mpy_mr got=%h want=ffff", alu_out); end
        total++; if (alu_out_valid !== 1'b1) begin bad++; $display("FAIL mpy_valid_after got=%b want=1", alu_out_valid); end
        control_signal = '0;
        issue(cb(B_ADD), 16'h0, mu, cy);
        total++; if (acc_out !== 16'h1225) begin bad++; $display("FAIL mpy_br_during_busy got=%h want=1225", acc_out); end
    endtask

    task automatic test_div();
        bit mu; int cy;
        issue(cb(B_MBR2BR), 16'd7, mu, cy);
        issue(cb(B_MBR2ACC), 16'd100, mu, cy);
        issue(cb(B_DIV), 16'h0, mu, cy);
        total++; if (cy != 17) begin bad++; $display("FAIL div_busy_cycles got=%0d want=17", cy); end
        total++; if (acc_out !== 16'd14) begin bad++; $display("FAIL div_pos_q got=%h want=000e", acc_out); end
        total++; if (alu_out !== 16'd2) begin bad++; $display("FAIL div_pos_r got=%h want=0002", alu_out); end
        issue(cb(B_MBR2ACC), 16'hFF9C, mu, cy);
        issue(cb(B_DIV), 16'h0, mu, cy);
        total++; if (acc_out !== 16'hFFF2) begin bad++; $display("FAIL div_neg_q got=%h want=fff2", acc_out); end
        total++; if (alu_out !== 16'hFFFE) begin bad++; $display("FAIL div_neg_r got=%h want=fffe", alu_out); end
        issue(cb(B_MBR2BR), 16'h0, mu, cy);
        issue(cb(B_MBR2ACC), 16'h1234, mu, cy);
        issue(cb(B_DIV), 16'h0, mu, cy);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL div0_busy got=%b want=0", busy); end
        total++; if (acc_out !== 16'hFFFF) begin bad++; $display("FAIL div0_acc got=%h want=ffff", acc_out); end
        total++; if (alu_out !== 16'h1234) begin bad++; $display("FAIL div0_mr got=%h want=1234", alu_out); end
        total++; if (flags[4] !== 1'b1) begin bad++; $display("FAIL div0_dz got=%b want=1", flags[4]); end
        issue(cb(B_MBR2BR), 16'd7, mu, cy);
        issue(cb(B_DIV), 16'h0, mu, cy);
        total++; if (acc_out !== 16'h0000 || alu_out !== 16'hFFFF) begin
            bad++; $display("FAIL div_m1_result got=%h/%h want=0000/ffff", acc_out, alu_out);
        end
        total++; if (flags[4] !== 1'b0) begin bad++; $display("FAIL div_dz_clear got=%b want=0", flags[4]); end
    endtask

    task automatic test_reset_mid();
        bit mu; int cy;
        issue(cb(B_MBR2BR), 16'd9, mu, cy);
        issue(cb(B_MBR2ACC), 16'd3, mu, cy);
        control_signal = cb(B_MPY);
        @(posedge clk); #1;
        control_signal = '0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (acc_out !== 16'h0 || alu_out !== 16'h0) begin
            bad++; $display("FAIL rstmid_regs got=%h/%h want=0000/0000", acc_out, alu_out);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        issue(cb(B_MBR2ACC), 16'd5, mu, cy);
        issue(cb(B_ADD), 16'h0, mu, cy);
        total++; if (acc_out !== 16'd5) begin bad++; $display("FAIL rstmid_br_cleared got=%h want=0005", acc_out); end
        issue(cb(B_MBR2BR), 16'd3, mu, cy);
        issue(cb(B_ADD), 16'h0, mu, cy);
        total++; if (acc_out !== 16'd8) begin bad++; $display("FAIL rstmid_add got=%h want=0008", acc_out); end
    endtask

    task automatic test_random();
        bit mu; int cy;
        int ops [13];
        logic [31:0] cw;
        logic [15:0] mbr;
        ops = '{B_CLR, B_MBR2ACC, B_DIV, B_ADD, B_SUB, B_AND, B_OR, B_NOT, B_LSL, B_LSR, B_MPY, B_ASL, B_ASR};
        for (int i = 0; i < 300; i++) begin
            cw = cb(ops[$urandom_range(0, 12)]);
            if ($urandom_range(0, 3) == 0) cw = cw | cb(ops[$urandom_range(0, 12)]);
            if ($urandom_range(0, 1) == 1) cw = cw | cb(B_MBR2BR);
            cw = cw | (32'($urandom) & 32'h0000_A0BF);
            mbr = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            issue(cw, mbr, mu, cy);
            if (mu) begin
                total++; if (cy != 17) begin bad++; $display("FAIL rnd%0d_busy_cycles got=%0d want=17", i, cy); end
            end
            total++; if (acc_out !== m_acc) begin bad++; $display("FAIL rnd%0d_acc cw=%h got=%h want=%h", i, cw, acc_out, m_acc); end
            total++; if (alu_out !== m_mr) begin bad++; $display("FAIL rnd%0d_mr cw=%h got=%h want=%h", i, cw, alu_out, m_mr); end
            total++; if (flags !== m_flags()) begin bad++; $display("FAIL rnd%0d_flags cw=%h got=%h want=%h", i, cw, flags, m_flags()); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy got=%b want=0", i, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_overflow();
        test_shifts();
        test_mpy();
        test_div();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
